// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop synchronized input, majority-vote oversampling, LSB-first data, optional parity.
// All bit timing counts ce ticks; dataout/ready/error are registered together on the STOP clock.
module uart_rx_core #(
  parameter int DATA_WIDTH    = 8,
  parameter int COUNTER_WIDTH = 24,
  parameter int SAMPLE_COUNT  = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ce,
  input  logic                       uart_rxpin,
  input  logic [COUNTER_WIDTH+7:0]   settings,
  output logic [DATA_WIDTH-1:0]      dataout,
  output logic                       uart_rx_ready,
  output logic                       uart_rx_error
);

  localparam int VW    = $clog2(SAMPLE_COUNT + 1);
  localparam int SHIFT = $clog2(SAMPLE_COUNT + 1);
  localparam int IW    = $clog2(DATA_WIDTH + 1);
  localparam logic [VW-1:0] VOTE_MAX  = VW'(SAMPLE_COUNT);
  localparam logic [VW-1:0] VOTE_HALF = VW'(SAMPLE_COUNT / 2);
  localparam logic [IW-1:0] DW_BITS   = IW'(DATA_WIDTH);

  typedef enum logic [2:0] {IDLE, START, READ, PARITY, STOP} state_t;
  state_t state, state_nxt;

  logic                     rx_meta, rx_sync;
  logic [COUNTER_WIDTH-1:0] period_q, period_cnt, period_inc;
  logic [COUNTER_WIDTH-1:0] intv_cnt, intv_inc, intv;
  logic [IW-1:0]            databits_q, bit_idx;
  logic [1:0]               parity_q;
  logic [VW-1:0]            vote, smp_cnt;
  logic [DATA_WIDTH-1:0]    word;
  logic                     par_acc, par_err;
  logic                     vote_bit, boundary, sample_hit, last_bit;
  logic [3:0]               db_raw;
  logic                     unused_stopbits;

  assign db_raw          = settings[COUNTER_WIDTH+3:COUNTER_WIDTH];
  assign unused_stopbits = ^settings[COUNTER_WIDTH+7:COUNTER_WIDTH+6];

  // Sample interval is P/(SAMPLE_COUNT+1); SAMPLE_COUNT+1 is a power of two.
  always_comb begin
    intv = period_q >> SHIFT;
    if (intv == '0) intv = COUNTER_WIDTH'(1);
  end

  assign period_inc = period_cnt + COUNTER_WIDTH'(1);
  assign intv_inc   = intv_cnt + COUNTER_WIDTH'(1);
  assign vote_bit   = (vote > VOTE_HALF);
  assign boundary   = ce && (state != IDLE) && (period_inc == period_q);
  assign sample_hit = ce && (state != IDLE) && (intv_inc == intv) && (smp_cnt != VOTE_MAX);
  assign last_bit   = ((bit_idx + IW'(1)) == databits_q);

  always_comb begin
    par_err = 1'b0;
    case (parity_q)
      2'd1:    par_err = ~par_acc;
      2'd2:    par_err = par_acc;
      2'd3:    par_err = 1'b1;
      default: par_err = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= uart_rxpin;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ce && !rx_sync) state_nxt = START;
      START:   if (boundary) state_nxt = vote_bit ? IDLE : READ;
      READ:    if (boundary && last_bit) state_nxt = PARITY;
      PARITY:  if ((parity_q == 2'd0) || boundary) state_nxt = STOP;
      STOP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Frame settings track the input while idle and freeze once a start edge is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_q   <= '0;
      databits_q <= DW_BITS;
      parity_q   <= 2'd0;
    end else if (state == IDLE) begin
      period_q   <= settings[COUNTER_WIDTH-1:0];
      databits_q <= ((db_raw == 4'd0) || (int'(db_raw) > DATA_WIDTH)) ? DW_BITS : IW'(db_raw);
      parity_q   <= settings[COUNTER_WIDTH+5:COUNTER_WIDTH+4];
    end
  end

  // Vote counter carries over between bits; saturation gives hysteresis against glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_cnt <= '0;
      intv_cnt   <= '0;
      smp_cnt    <= '0;
      vote       <= VOTE_MAX;
    end else if ((state == IDLE) || boundary) begin
      period_cnt <= '0;
      intv_cnt   <= '0;
      smp_cnt    <= '0;
      if (state == IDLE) vote <= VOTE_MAX;
    end else if (ce) begin
      period_cnt <= period_inc;
      if (sample_hit) begin
        intv_cnt <= '0;
        smp_cnt  <= smp_cnt + VW'(1);
        if (rx_sync) begin
          if (vote != VOTE_MAX) vote <= vote + VW'(1);
        end else if (vote != '0) begin
          vote <= vote - VW'(1);
        end
      end else begin
        intv_cnt <= intv_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word          <= '0;
      bit_idx       <= '0;
      par_acc       <= 1'b0;
      dataout       <= '0;
      uart_rx_ready <= 1'b0;
      uart_rx_error <= 1'b0;
    end else begin
      uart_rx_ready <= 1'b0;
      uart_rx_error <= 1'b0;
      case (state)
        START: begin
          if (boundary) begin
            word    <= '0;
            bit_idx <= '0;
            par_acc <= 1'b0;
          end
        end
        READ: begin
          if (boundary) begin
            word    <= word | (DATA_WIDTH'(vote_bit) << bit_idx);
            bit_idx <= bit_idx + IW'(1);
            par_acc <= par_acc ^ vote_bit;
          end
        end
        PARITY: begin
          if (boundary && (parity_q != 2'd0)) par_acc <= par_acc ^ vote_bit;
        end
        STOP: begin
          dataout       <= word;
          uart_rx_ready <= 1'b1;
          uart_rx_error <= par_err;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: a tick-level frame decoder model checks outputs every clock,
// and literal expectations pin each scenario.
`timescale 1ns/1ps
module tb_uart_rx_core;
  localparam int DW = 8;
  localparam int CW = 24;
  localparam int SC = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          ce;
  logic          uart_rxpin;
  logic [CW+7:0] settings;
  logic [DW-1:0] dataout;
  logic          uart_rx_ready;
  logic          uart_rx_error;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int ce_div  = 1;
  int ce_ctr  = 0;

  uart_rx_core #(.DATA_WIDTH(DW), .COUNTER_WIDTH(CW), .SAMPLE_COUNT(SC)) dut (
    .clk(clk), .rst(rst), .ce(ce), .uart_rxpin(uart_rxpin), .settings(settings),
    .dataout(dataout), .uart_rx_ready(uart_rx_ready), .uart_rx_error(uart_rx_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ce tick generator: one tick every ce_div clocks
  initial begin
    ce = 1'b1;
    forever begin
      @(posedge clk); #1;
      ce_ctr = (ce_ctr + 1 >= ce_div) ? 0 : ce_ctr + 1;
      ce = (ce_ctr == 0);
    end
  end

  // What the receiver logic sees of the line: two clocks of delay, high on reset
  logic s1, s2;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= uart_rxpin;
      s2 <= s1;
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    int            edge_n;
    logic [DW-1:0] d;
    logic          e;
  } exp_t;
  exp_t exp_q[$];
  logic m_ab = 1'b0;

  // One call = one upcoming clock edge, returning what that edge will act on.
  task automatic step(output logic c, output logic l);
    @(negedge clk);
    c = ce;
    l = s2;
    if (rst) m_ab = 1'b1;
  endtask

  task automatic model_frame();
    int p, db, par, iv, nb, t, vote, el;
    logic c, l, b, acc;
    logic [DW-1:0] w;
    exp_t x;
    p   = int'(settings[CW-1:0]);
    db  = int'(settings[CW+3:CW]);
    if (db == 0 || db > DW) db = DW;
    par = int'(settings[CW+5:CW+4]);
    iv  = p / (SC + 1);
    if (iv < 1) iv = 1;
    nb   = 1 + db + ((par != 0) ? 1 : 0);
    vote = SC;
    w    = '0;
    acc  = 1'b0;
    el   = 0;
    for (int k = 0; k < nb; k++) begin
      t = 0;
      while (t < p) begin
        step(c, l);
        if (m_ab) return;
        if (c) begin
          t++;
          if (t < p && (t % iv) == 0 && (t / iv) <= SC) begin
            if (l) vote = (vote < SC) ? vote + 1 : SC;
            else   vote = (vote > 0) ? vote - 1 : 0;
          end
        end
      end
      el = cyc + 1;
      b  = (vote > SC / 2);
      if (k == 0) begin
        if (b) return;
      end else if (k <= db) begin
        w[k-1] = b;
        acc    = acc ^ b;
      end else begin
        acc = acc ^ b;
      end
    end
    x.edge_n = el + ((par != 0) ? 1 : 2);
    x.d      = w;
    x.e      = (par == 1) ? ~acc : (par == 2) ? acc : (par == 3);
    exp_q.push_back(x);
    repeat ((par != 0) ? 1 : 2) begin
      step(c, l);
      if (m_ab) return;
    end
  endtask

  initial begin
    logic c, l;
    forever begin
      step(c, l);
      if (m_ab) begin
        m_ab = 1'b0;
        continue;
      end
      if (c && !l) begin
        model_frame();
        m_ab = 1'b0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [DW-1:0] exp_data = '0;
  logic [DW-1:0] got_d[$];
  logic          got_e[$];

  initial begin
    logic er;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        exp_data = '0;
        check("rst dataout", dataout, exp_data);
        check("rst ready", uart_rx_ready, 1'b0);
        check("rst error", uart_rx_error, 1'b0);
      end else begin
        er = (exp_q.size() > 0) && (exp_q[0].edge_n == cyc);
        check("ready strobe", uart_rx_ready, er);
        if (er) begin
          exp_data = exp_q[0].d;
          check("error strobe", uart_rx_error, exp_q[0].e);
          exp_q.pop_front();
        end else begin
          check("error idle", uart_rx_error, 1'b0);
        end
        check("dataout", dataout, exp_data);
        if (uart_rx_ready) begin
          got_d.push_back(dataout);
          got_e.push_back(uart_rx_error);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [CW+7:0] mk(input int p, input int db, input int par);
    logic [CW+7:0] s;
    s = '0;
    s[CW-1:0]     = CW'(p);
    s[CW+3:CW]    = 4'(db);
    s[CW+5:CW+4]  = 2'(par);
    return s;
  endfunction

  task automatic seg(input logic v, input int n);
    int t;
    #1 uart_rxpin = v;
    t = 0;
    while (t < n) begin
      @(posedge clk);
      if (ce) t++;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb, input bit has_par, input logic pb);
    seg(1'b0, 16);
    for (int i = 0; i < nb; i++) seg(d[i], 16);
    if (has_par) seg(pb, 16);
    seg(1'b1, 16);
    seg(1'b1, 4);
  endtask

  task automatic expect_one(input string name, input logic [7:0] d, input logic e);
    check({name, " count"}, got_d.size(), 1);
    if (got_d.size() > 0) begin
      check({name, " data"}, got_d[0], d);
      check({name, " err"}, got_e[0], e);
    end
    got_d.delete();
    got_e.delete();
  endtask

  initial begin
    rst        = 1'b1;
    uart_rxpin = 1'b1;
    settings   = mk(16, 8, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post-reset dataout", dataout, 8'h00);
    check("post-reset ready", uart_rx_ready, 1'b0);
    seg(1'b1, 20);

    // 8N1 0xA5, then quiet line
    send_frame(8'hA5, 8, 1'b0, 1'b0);
    expect_one("8N1 A5", 8'hA5, 1'b0);
    seg(1'b1, 40);
    check("no extra pulses", got_d.size(), 0);

    // odd parity 0x03
    settings = mk(16, 8, 1);
    seg(1'b1, 4);
    send_frame(8'h03, 8, 1'b1, 1'b1);
    expect_one("odd good", 8'h03, 1'b0);
    send_frame(8'h03, 8, 1'b1, 1'b0);
    expect_one("odd bad", 8'h03, 1'b1);

    // two-tick glitch is a false start
    settings = mk(16, 8, 0);
    seg(1'b1, 4);
    seg(1'b0, 2);
    seg(1'b1, 40);
    check("glitch no ready", got_d.size(), 0);
    check("glitch dataout held", dataout, 8'h03);
    send_frame(8'h5A, 8, 1'b0, 1'b0);
    expect_one("after glitch 5A", 8'h5A, 1'b0);

    // single-tick low hitting the first sample of high data bit 3
    seg(1'b0, 16);
    for (int i = 0; i < 3; i++) seg(1'b1, 16);
    seg(1'b1, 4);
    seg(1'b0, 1);
    seg(1'b1, 11);
    for (int i = 4; i < 8; i++) seg(1'b1, 16);
    seg(1'b1, 20);
    expect_one("bit glitch FF", 8'hFF, 1'b0);

    // 7 data bits, then databits=0 meaning full width
    settings = mk(16, 7, 0);
    seg(1'b1, 4);
    send_frame(8'h7F, 7, 1'b0, 1'b0);
    expect_one("7 bits 7F", 8'h7F, 1'b0);
    settings = mk(16, 0, 0);
    seg(1'b1, 4);
    send_frame(8'hFF, 8, 1'b0, 1'b0);
    expect_one("db0 FF", 8'hFF, 1'b0);

    // stalled ce: even parity good, then invalid parity code
    ce_div   = 3;
    settings = mk(16, 8, 2);
    seg(1'b1, 4);
    send_frame(8'h3C, 8, 1'b1, 1'b0);
    expect_one("even stalled", 8'h3C, 1'b0);
    settings = mk(16, 8, 3);
    seg(1'b1, 4);
    send_frame(8'h3C, 8, 1'b1, 1'b0);
    expect_one("parity code 3", 8'h3C, 1'b1);
    ce_div   = 1;
    settings = mk(16, 8, 0);
    seg(1'b1, 8);

    // reset in the middle of data bit 4
    seg(1'b0, 16);
    for (int i = 0; i < 4; i++) seg(1'b1, 16);
    seg(1'b0, 8);
    #1 rst = 1'b1;
    uart_rxpin = 1'b1;
    #1;
    check("mid-frame rst dataout", dataout, 8'h00);
    check("mid-frame rst ready", uart_rx_ready, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    seg(1'b1, 32);
    check("aborted frame no ready", got_d.size(), 0);

    // back-to-back frames
    seg(1'b0, 16);
    for (int i = 0; i < 8; i++) seg(((8'h11 >> i) & 8'h01) != 0, 16);
    seg(1'b1, 16);
    send_frame(8'h22, 8, 1'b0, 1'b0);
    check("b2b count", got_d.size(), 2);
    if (got_d.size() == 2) begin
      check("b2b first", got_d[0], 8'h11);
      check("b2b second", got_d[1], 8'h22);
    end
    got_d.delete();
    got_e.delete();

    seg(1'b1, 8);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
